uart_rx_core: RTL and testbench
===============================

// Module: uart_rx_core
// PURPOSE
//   Serial receive engine feeding the MiniUART register file (rx_data/rs/read_over).
//   Oversamples RxD on baud-rate enable ticks from the divisor, validates the start bit
//   and shifts in an 8N1 frame LSB first. Presents the byte with a ready flag, a framing
//   error flag and an overrun flag until the bus side acknowledges with read_over.
// PARAMETERS
//   DATA_BITS   8    data bits per frame; bit counter width is clog2(DATA_BITS)
//   OVERSAMPLE  16   en_rx ticks per bit time; must be even and >= 4
// PORTS
//   CLK_I      in   1          system clock; all flops on posedge
//   RST_I      in   1          asynchronous, active-high reset
//   RxD        in   1          raw serial input, idle high; asynchronous to CLK_I
//   en_rx      in   1          one-CLK_I pulse, OVERSAMPLE pulses per bit time
//   read_over  in   1          bus acknowledge; clears rs, frame_err and overrun
//   rx_data    out  DATA_BITS  last received byte
//   rs         out  1          receive-ready status
//   frame_err  out  1          stop bit of the last stored frame sampled low
//   overrun    out  1          a frame completed while rs was already 1
// BEHAVIOUR
//   Reset values: rx_data=0, rs=0, frame_err=0, overrun=0, state=IDLE, counters=0,
//     both synchroniser flops=1. Reset mid-frame abandons the frame with no flag set.
//   Synchroniser: two-flop chain on RxD clocked every CLK_I. rxs is the second flop.
//     The FSM uses only rxs.
//   FSM and counter advance only on cycles with en_rx=1. They hold otherwise.
//   tick: log2(OVERSAMPLE)-bit counter. bitn: bit counter. sh: DATA_BITS shift register.
//   IDLE : on rxs=0, tick<=0 and go to START.
//   START: tick++. At tick==OVERSAMPLE/2-1, sample rxs:
//          0 -> tick<=0, bitn<=0, go to DATA.
//          1 -> glitch, go to IDLE with no flag set.
//   DATA : tick++. At tick==OVERSAMPLE-1 (bit centre), sh<={rxs,sh[DATA_BITS-1:1]}
//          and tick wraps to 0. When bitn==DATA_BITS-1, go to STOP; otherwise bitn++.
//   STOP : tick++. At tick==OVERSAMPLE-1, complete the frame and go to IDLE:
//          rx_data<=sh, rs<=1, frame_err<=~rxs, overrun<=rs.
//          A frame with a bad stop bit is still stored.
//   Latency: rs rises on the clock edge of the en_rx tick at the stop-bit centre.
//     That edge falls 9.5 bit times after the falling edge of the start bit,
//     plus 2-3 CLK_I of synchroniser delay.
//   IDLE re-arms immediately. A start edge is accepted during the remaining half stop bit.
//   read_over=1 (level, any cycle): rs, frame_err and overrun all clear on the next edge.
//   Completion and read_over on the same edge: completion wins.
//     rs=1, frame_err from the new frame, overrun=0 (the old byte was consumed).
//   An overrun overwrites rx_data. overrun stays 1 until read_over.
//   rx_data is never cleared except by reset.
//   en_rx held at 1 continuously is legal. The FSM then runs at CLK_I rate.
// TESTING
//   1. Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) at 16 ticks/bit.
//      -> rx_data=0xA5, rs=1, frame_err=0, overrun=0. rs rises at the stop-bit centre tick.
//   2. RxD low for 5 ticks then high. -> FSM returns to IDLE; rs stays 0, rx_data unchanged.
//   3. Send 0x3C with the stop bit low, then pulse read_over.
//      -> rx_data=0x3C, rs=1, frame_err=1; after read_over, rs=0 and frame_err=0.
//   4. Send 0x11 then 0x22 back to back with no read_over.
//      -> rx_data=0x22, rs=1, overrun=1.
//   5. Hold read_over=1 through the completion edge of 0x5A.
//      -> rs=1 and overrun=0 after that edge; rs=0 on the next edge.
//   6. Assert RST_I during bit 4 of 0xFF, release it, then send 0x81.
//      -> outputs are 0 during reset; the next frame is received cleanly as 0x81.

Source files
------------

// File: rtl/uart_rx_core_if.sv
// Bus-side view of the UART receive core: received byte, status flags and the read acknowledge.
interface uart_rx_core_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic                 read_over;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rs;
  logic                 frame_err;
  logic                 overrun;

  // Register-file side: consumes the byte and acknowledges it.
  modport master (
    output read_over,
    input  rx_data,
    input  rs,
    input  frame_err,
    input  overrun
  );

  // Receive core side: presents the byte and flags.
  modport slave (
    input  read_over,
    output rx_data,
    output rs,
    output frame_err,
    output overrun
  );
endinterface

// File: rtl/uart_rx_core.sv
// Oversampling 8N1 UART receiver: synchronises RxD, validates the start bit, shifts data LSB first
// and holds the byte with ready/framing/overrun status until the bus acknowledges with read_over.
module uart_rx_core #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic                RxD,
  input  logic                en_rx,
  uart_rx_core_if.slave       bus
);

  localparam int unsigned TICK_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BITN_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BITN_W-1:0] BITN_LAST = BITN_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               r_state,   w_state_n;
  logic [TICK_W-1:0]    r_tick,    w_tick_n;
  logic [BITN_W-1:0]    r_bitn,    w_bitn_n;
  logic [DATA_BITS-1:0] r_sh,      w_sh_n;
  logic [DATA_BITS-1:0] r_rx_data, w_rx_data_n;
  logic                 r_rs,      w_rs_n;
  logic                 r_fe,      w_fe_n;
  logic                 r_ov,      w_ov_n;
  logic                 r_sync1;
  logic                 r_rxs;
  logic                 w_done;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= RxD;
      r_rxs   <= r_sync1;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state   <= S_IDLE;
      r_tick    <= '0;
      r_bitn    <= '0;
      r_sh      <= '0;
      r_rx_data <= '0;
      r_rs      <= 1'b0;
      r_fe      <= 1'b0;
      r_ov      <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_tick    <= w_tick_n;
      r_bitn    <= w_bitn_n;
      r_sh      <= w_sh_n;
      r_rx_data <= w_rx_data_n;
      r_rs      <= w_rs_n;
      r_fe      <= w_fe_n;
      r_ov      <= w_ov_n;
    end
  end

  // Frame sequencing; everything holds on cycles without an oversample tick.
  always_comb begin
    w_state_n = r_state;
    w_tick_n  = r_tick;
    w_bitn_n  = r_bitn;
    w_sh_n    = r_sh;
    w_done    = 1'b0;
    if (en_rx) begin
      case (r_state)
        S_IDLE: begin
          if (!r_rxs) begin
            w_tick_n  = '0;
            w_state_n = S_START;
          end
        end
        S_START: begin
          w_tick_n = r_tick + TICK_W'(1);
          if (r_tick == TICK_HALF) begin
            if (!r_rxs) begin
              w_tick_n  = '0;
              w_bitn_n  = '0;
              w_state_n = S_DATA;
            end else begin
              w_state_n = S_IDLE;
            end
          end
        end
        S_DATA: begin
          w_tick_n = r_tick + TICK_W'(1);
          if (r_tick == TICK_LAST) begin
            w_tick_n = '0;
            w_sh_n   = {r_rxs, r_sh[DATA_BITS-1:1]};
            if (r_bitn == BITN_LAST) begin
              w_state_n = S_STOP;
            end else begin
              w_bitn_n = r_bitn + BITN_W'(1);
            end
          end
        end
        S_STOP: begin
          w_tick_n = r_tick + TICK_W'(1);
          if (r_tick == TICK_LAST) begin
            w_tick_n  = '0;
            w_done    = 1'b1;
            w_state_n = S_IDLE;
          end
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  // Status: a completing frame takes precedence over an acknowledge on the same edge.
  always_comb begin
    w_rx_data_n = r_rx_data;
    w_rs_n      = r_rs;
    w_fe_n      = r_fe;
    w_ov_n      = r_ov;
    if (w_done) begin
      w_rx_data_n = r_sh;
      w_rs_n      = 1'b1;
      w_fe_n      = ~r_rxs;
      w_ov_n      = r_rs & ~bus.read_over;
    end else if (bus.read_over) begin
      w_rs_n = 1'b0;
      w_fe_n = 1'b0;
      w_ov_n = 1'b0;
    end
  end

  assign bus.rx_data   = r_rx_data;
  assign bus.rs        = r_rs;
  assign bus.frame_err = r_fe;
  assign bus.overrun   = r_ov;

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: directed frames at 16 ticks/bit (en_rx every 4 clocks)
// and one frame with en_rx held high; a negedge monitor checks every completed frame.
module tb_uart_rx_core;

  logic CLK_I = 1'b0;
  logic RST_I = 1'b1;
  logic RxD   = 1'b1;
  logic en_rx = 1'b0;
  logic en_cont = 1'b0;

  int tests = 0;
  int fails = 0;
  int lat_n = 0;
  int wait_n = 0;
  int tick_cnt = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       ov;
  } exp_t;

  exp_t exp_q[$];

  uart_rx_core_if #(.DATA_BITS(8)) bus ();

  uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .RxD   (RxD),
    .en_rx (en_rx),
    .bus   (bus)
  );

  always #5 CLK_I = ~CLK_I;

  // Oversample tick: one clock in four, or every clock when en_cont is set.
  initial begin
    forever begin
      @(negedge CLK_I);
      tick_cnt = tick_cnt + 1;
      en_rx = en_cont || (tick_cnt % 4 == 0);
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK_I);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int bit_clks);
    RxD = 1'b0;
    idle(bit_clks);
    for (int i = 0; i < 8; i++) begin
      RxD = d[i];
      idle(bit_clks);
    end
    RxD = stop_bit;
    idle(bit_clks);
    RxD = 1'b1;
  endtask

  task automatic pulse_read_over;
    bus.read_over = 1'b1;
    idle(1);
    bus.read_over = 1'b0;
  endtask

  // Monitor: a frame completion shows as rs rising, or new data/flags while rs is already set.
  logic [7:0] p_data = '0;
  logic       p_rs = 1'b0, p_fe = 1'b0, p_ov = 1'b0;
  exp_t       got, want;

  always @(negedge CLK_I) begin
    if (RST_I) begin
      p_data = '0; p_rs = 1'b0; p_fe = 1'b0; p_ov = 1'b0;
    end else begin
      if (bus.rs && (!p_rs || bus.rx_data !== p_data || (bus.overrun && !p_ov) ||
                     bus.frame_err !== p_fe)) begin
        tests = tests + 1;
        got = {bus.rx_data, bus.frame_err, bus.overrun};
        if (exp_q.size() == 0) begin
          fails = fails + 1;
          $display("FAIL unexpected_frame: got data=%0h fe=%0b ov=%0b with nothing expected",
                   got.d, got.fe, got.ov);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            fails = fails + 1;
            $display("FAIL frame: got data=%0h fe=%0b ov=%0b expected data=%0h fe=%0b ov=%0b",
                     got.d, got.fe, got.ov, want.d, want.fe, want.ov);
          end
        end
      end
      p_data = bus.rx_data; p_rs = bus.rs; p_fe = bus.frame_err; p_ov = bus.overrun;
    end
  end

  initial begin
    bus.read_over = 1'b0;
    idle(3);
    check("reset_rx_data", 32'(bus.rx_data), 32'h0);
    check("reset_flags", 32'({bus.rs, bus.frame_err, bus.overrun}), 32'h0);
    RST_I = 1'b0;
    idle(20);

    // 1: clean 0xA5; rs must rise 9.5 bit times (608 clocks) plus sync/tick phase after the start edge
    exp_q.push_back('{8'hA5, 1'b0, 1'b0});
    fork
      send_frame(8'hA5, 1'b1, 64);
      begin
        lat_n = 0;
        while (!bus.rs && lat_n < 800) begin
          @(negedge CLK_I);
          lat_n = lat_n + 1;
        end
        check("latency_window", 32'((lat_n >= 609) && (lat_n <= 617)), 32'h1);
        if (lat_n < 609 || lat_n > 617) $display("  latency was %0d clocks", lat_n);
      end
    join
    idle(64);
    pulse_read_over();

    // 2: five-tick glitch must not start a frame
    RxD = 1'b0;
    idle(20);
    RxD = 1'b1;
    idle(192);
    check("glitch_rs", 32'(bus.rs), 32'h0);
    check("glitch_rx_data", 32'(bus.rx_data), 32'hA5);

    // 3: 0x3C with a low stop bit, then acknowledge
    exp_q.push_back('{8'h3C, 1'b1, 1'b0});
    send_frame(8'h3C, 1'b0, 64);
    idle(128);
    check("fe_set", 32'(bus.frame_err), 32'h1);
    pulse_read_over();
    check("ack_clears", 32'({bus.rs, bus.frame_err, bus.overrun}), 32'h0);
    idle(64);

    // 4: back-to-back 0x11, 0x22 without acknowledge
    exp_q.push_back('{8'h11, 1'b0, 1'b0});
    exp_q.push_back('{8'h22, 1'b0, 1'b1});
    send_frame(8'h11, 1'b1, 64);
    send_frame(8'h22, 1'b1, 64);
    idle(64);
    check("overrun_data", 32'(bus.rx_data), 32'h22);
    check("overrun_flag", 32'({bus.rs, bus.overrun}), 32'h3);

    // 5: read_over held through completion of 0x5A
    exp_q.push_back('{8'h5A, 1'b0, 1'b0});
    bus.read_over = 1'b1;
    fork
      send_frame(8'h5A, 1'b1, 64);
      begin
        wait_n = 0;
        while (!bus.rs && wait_n < 1000) begin
          @(negedge CLK_I);
          wait_n = wait_n + 1;
        end
        check("held_ack_rs_rises", 32'(bus.rs), 32'h1);
        @(negedge CLK_I);
        check("held_ack_rs_next", 32'(bus.rs), 32'h0);
      end
    join
    bus.read_over = 1'b0;
    idle(64);

    // 6: reset in bit 4 of 0xFF, then a clean 0x81
    RxD = 1'b0;
    idle(64);
    RxD = 1'b1;
    idle(4 * 64 + 32);
    RST_I = 1'b1;
    idle(1);
    check("midreset_rx_data", 32'(bus.rx_data), 32'h0);
    check("midreset_flags", 32'({bus.rs, bus.frame_err, bus.overrun}), 32'h0);
    idle(3);
    RST_I = 1'b0;
    idle(5 * 64);
    check("post_reset_idle_rs", 32'(bus.rs), 32'h0);
    exp_q.push_back('{8'h81, 1'b0, 1'b0});
    send_frame(8'h81, 1'b1, 64);
    idle(64);
    pulse_read_over();

    // 7: en_rx held high, 16 clocks per bit
    en_cont = 1'b1;
    idle(4);
    exp_q.push_back('{8'h96, 1'b0, 1'b0});
    send_frame(8'h96, 1'b1, 16);
    idle(64);
    check("cont_rx_data", 32'(bus.rx_data), 32'h96);
    en_cont = 1'b0;
    idle(16);

    check("all_frames_seen", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
